// File: rtl/next_pc_unit.sv
// next_pc_unit: owns the architectural fetch PC and resolves branch/jump
// redirects with MIPS delay-slot semantics. Stalls hold the PC. Redirects
// that arrive while stalled are buffered until the stall clears.
// Optional return-address check stack: define NPC_RAS_EN to build it.
module next_pc_unit #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_stall,
  input  logic            w_branch_op,
  input  logic            w_success,
  input  logic            w_jump_op,
  input  logic            w_imm_op,
  input  logic            w_link,
  input  logic            w_ret,
  input  logic [PC_W-1:0] w_br_pc_in,
  input  logic [PC_W-1:0] w_alu_imm,
  input  logic [25:0]     w_br_imm_26,
  input  logic [PC_W-1:0] w_reg_pc,
  output logic [PC_W-1:0] w_pc,
  output logic            w_redirect,
  output logic            w_misalign,
  output logic            w_redir_drop,
  output logic            w_ras_hit,
  output logic            w_ras_miss
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SLOT = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] FOUR   = PC_W'(4);
  localparam logic [PC_W-1:0] EIGHT  = PC_W'(8);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [PC_W-1:0] br_q, br_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic            drop_q, drop_d;

  logic            take;
  logic            accept;
  logic [PC_W-1:0] ds;
  logic [PC_W-1:0] tgt_raw;
  logic [PC_W-1:0] tgt_al;

  assign take   = (w_branch_op & w_success) | w_jump_op;
  assign accept = take & (state_q == ST_RUN);
  assign ds     = w_br_pc_in + FOUR;
  assign tgt_al = {tgt_raw[PC_W-1:2], 2'b00};

  // Redirect target selection; a jump takes priority over a branch.
  always_comb begin
    tgt_raw = ds + w_alu_imm;
    if (w_jump_op) begin
      if (w_imm_op) begin
        tgt_raw       = ds;
        tgt_raw[27:0] = {w_br_imm_26, 2'b00};
      end else begin
        tgt_raw = w_reg_pc;
      end
    end
  end

  // Next-state, next-PC and pulse generation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    br_d       = br_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (take) begin
          misalign_d = |tgt_raw[1:0];
          tgt_d      = tgt_al;
          br_d       = w_br_pc_in;
          if (pc_q == w_br_pc_in) begin
            // Delay slot not fetched yet: fetch it (unless stalled) before
            // the target.
            state_d = ST_SLOT;
            if (!w_stall) begin
              pc_d = ds;
            end
          end else if (!w_stall) begin
            // Delay slot already fetched, or no slot relationship at all:
            // both go straight to the target.
            pc_d       = tgt_al;
            redirect_d = 1'b1;
          end else begin
            state_d = ST_PEND;
          end
        end else if (!w_stall) begin
          pc_d = pc_q + FOUR;
        end
      end
      ST_SLOT: begin
        drop_d = take;
        if (!w_stall) begin
          if (pc_q == br_q) begin
            pc_d = br_q + FOUR;
          end else begin
            pc_d       = tgt_q;
            redirect_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_PEND: begin
        drop_d = take;
        if (!w_stall) begin
          pc_d       = tgt_q;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // PC, pending-redirect and pulse registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RST;
      tgt_q      <= '0;
      br_q       <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      br_q       <= br_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      drop_q     <= drop_d;
    end
  end

  assign w_pc         = pc_q;
  assign w_redirect   = redirect_q;
  assign w_misalign   = misalign_q;
  assign w_redir_drop = drop_q;

`ifdef NPC_RAS_EN
  localparam int unsigned RP_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RP_W:0] RAS_FULL = (RP_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] ras_d [RAS_DEPTH];
  logic [RP_W-1:0] sp_q, sp_d;
  logic [RP_W:0]   cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;

  logic            push;
  logic            pop;
  logic [RP_W-1:0] top;
  logic [PC_W-1:0] link_addr;
  logic [PC_W-1:0] ret_addr;

  assign push      = accept & w_link;
  assign pop       = accept & w_jump_op & ~w_imm_op & w_ret;
  assign top       = sp_q - RP_W'(1);
  assign link_addr = w_br_pc_in + EIGHT;
  assign ret_addr  = {w_reg_pc[PC_W-1:2], 2'b00};

  // Return check and circular stack update; push+pop compares against the
  // old top and then overwrites it in place.
  always_comb begin
    ras_d  = ras_q;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    hit_d  = 1'b0;
    miss_d = 1'b0;
    if (pop) begin
      if (cnt_q == '0) begin
        miss_d = 1'b1;
      end else if (ras_q[top] == ret_addr) begin
        hit_d = 1'b1;
      end else begin
        miss_d = 1'b1;
      end
    end
    if (push && pop && (cnt_q != '0)) begin
      ras_d[top] = link_addr;
    end else if (push) begin
      ras_d[sp_q] = link_addr;
      sp_d        = sp_q + RP_W'(1);
      if (cnt_q != RAS_FULL) begin
        cnt_d = cnt_q + (RP_W+1)'(1);
      end
    end else if (pop && (cnt_q != '0)) begin
      sp_d  = top;
      cnt_d = cnt_q - (RP_W+1)'(1);
    end
  end

  // Return-stack registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
      sp_q   <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      ras_q  <= ras_d;
      sp_q   <= sp_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign w_ras_hit  = hit_q;
  assign w_ras_miss = miss_q;
`else
  logic unused_ras;
  assign unused_ras = ^{w_link, w_ret, accept, EIGHT[0], 1'(RAS_DEPTH)};
  assign w_ras_hit  = 1'b0;
  assign w_ras_miss = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  localparam int unsigned DEPTH = 2;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_stall, w_branch_op, w_success, w_jump_op, w_imm_op, w_link, w_ret;
  logic [31:0] w_br_pc_in, w_alu_imm, w_reg_pc, w_pc;
  logic [25:0] w_br_imm_26;
  logic        w_redirect, w_misalign, w_redir_drop, w_ras_hit, w_ras_miss;

  always #5 w_clk = ~w_clk;

  next_pc_unit #(
    .PC_W(32),
    .RESET_PC(32'h0000_0400),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_stall(w_stall),
    .w_branch_op(w_branch_op), .w_success(w_success), .w_jump_op(w_jump_op),
    .w_imm_op(w_imm_op), .w_link(w_link), .w_ret(w_ret),
    .w_br_pc_in(w_br_pc_in), .w_alu_imm(w_alu_imm), .w_br_imm_26(w_br_imm_26),
    .w_reg_pc(w_reg_pc), .w_pc(w_pc), .w_redirect(w_redirect),
    .w_misalign(w_misalign), .w_redir_drop(w_redir_drop),
    .w_ras_hit(w_ras_hit), .w_ras_miss(w_ras_miss)
  );

  typedef struct {
    bit          stall, br, succ, jmp, immop, link, ret;
    logic [31:0] br_pc, alu, reg_pc;
    logic [25:0] imm26;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] pc;
    bit          red, mis, drop;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: PC plus an optional "redirect owed" record, and the
  // return stack as a plain queue (oldest at the front).
  logic [31:0] m_pc, m_tgt, m_br;
  bit          m_pend, m_need_slot;
  bit          e_red, e_mis, e_drop, e_hit, e_miss;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.stall = 0; s.br = 0; s.succ = 0; s.jmp = 0; s.immop = 0; s.link = 0; s.ret = 0;
    s.br_pc = '0; s.alu = '0; s.reg_pc = '0; s.imm26 = '0;
    return s;
  endfunction

  function automatic vec_t mkv(bit st, bit br, bit su, bit jp, bit io,
                               logic [31:0] bpc, logic [31:0] alu, logic [25:0] i26,
                               logic [31:0] rpc, logic [31:0] pc, bit red, bit mis, bit drp);
    vec_t v;
    v.s = idle();
    v.s.stall = st; v.s.br = br; v.s.succ = su; v.s.jmp = jp; v.s.immop = io;
    v.s.br_pc = bpc; v.s.alu = alu; v.s.imm26 = i26; v.s.reg_pc = rpc;
    v.pc = pc; v.red = red; v.mis = mis; v.drop = drp;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h400; m_pend = 0; m_need_slot = 0; m_tgt = '0; m_br = '0;
    e_red = 0; e_mis = 0; e_drop = 0; e_hit = 0; e_miss = 0;
    m_ras.delete();
  endtask

  task automatic model_step(input stim_t s);
    logic [31:0] ds, t;
    bit take, pop;
    e_red = 0; e_mis = 0; e_drop = 0; e_hit = 0; e_miss = 0;
    take = (s.br && s.succ) || s.jmp;
    ds = s.br_pc + 32'd4;
    if (s.jmp && s.immop) t = (ds & 32'hF000_0000) | ({6'b0, s.imm26} << 2);
    else if (s.jmp)       t = s.reg_pc;
    else                  t = ds + s.alu;
    if (m_pend) begin
      e_drop = take;
      if (!s.stall) begin
        if (m_need_slot && m_pc == m_br) m_pc = m_br + 32'd4;
        else begin m_pc = m_tgt; m_pend = 0; e_red = 1; end
      end
    end else if (take) begin
      e_mis = (t % 4) != 0;
      t = t - (t % 4);
      pop = s.jmp && !s.immop && s.ret;
      if (pop) begin
        if (m_ras.size() == 0) e_miss = 1;
        else if (m_ras[m_ras.size()-1] == t) e_hit = 1;
        else e_miss = 1;
      end
      if (s.link && pop && m_ras.size() != 0) m_ras[m_ras.size()-1] = s.br_pc + 32'd8;
      else if (s.link) begin
        m_ras.push_back(s.br_pc + 32'd8);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (pop && m_ras.size() != 0) void'(m_ras.pop_back());
      if (m_pc == s.br_pc) begin
        m_pend = 1; m_need_slot = 1; m_br = s.br_pc; m_tgt = t;
        if (!s.stall) m_pc = ds;
      end else if (!s.stall) begin
        m_pc = t; e_red = 1;
      end else begin
        m_pend = 1; m_need_slot = 0; m_tgt = t;
      end
    end else if (!s.stall) begin
      m_pc = m_pc + 32'd4;
    end
`ifndef NPC_RAS_EN
    e_hit = 0; e_miss = 0;
`endif
  endtask

  // Drive one cycle at the falling edge, let the DUT clock, compare at the
  // next falling edge against the model.
  task automatic apply(input stim_t s);
    w_stall = s.stall; w_branch_op = s.br; w_success = s.succ; w_jump_op = s.jmp;
    w_imm_op = s.immop; w_link = s.link; w_ret = s.ret; w_br_pc_in = s.br_pc;
    w_alu_imm = s.alu; w_br_imm_26 = s.imm26; w_reg_pc = s.reg_pc;
    model_step(s);
    @(posedge w_clk);
    @(negedge w_clk);
    check("model_pc", w_pc, m_pc);
    check("model_redirect", 32'(w_redirect), 32'(e_red));
    check("model_misalign", 32'(w_misalign), 32'(e_mis));
    check("model_drop", 32'(w_redir_drop), 32'(e_drop));
    check("model_ras_hit", 32'(w_ras_hit), 32'(e_hit));
    check("model_ras_miss", 32'(w_ras_miss), 32'(e_miss));
  endtask

  vec_t vecs[$];

  initial begin
    stim_t s;
    int    v;
    bit    exp_hit, exp_miss;

    // Test plan vectors: stall,br,succ,jmp,imm, br_pc, alu, imm26, reg_pc -> pc, red, mis, drop
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h404, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h408, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h40C, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h410, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h414, 0,0,0));
    vecs.push_back(mkv(0,1,1,0,0, 32'h410, 32'h20, 26'h0, 32'h0, 32'h434, 1,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h438, 0,0,0));
    vecs.push_back(mkv(0,0,0,1,0, 32'h434, 32'h0,  26'h0, 32'h500, 32'h500, 1,0,0));
    vecs.push_back(mkv(0,0,0,1,1, 32'h500, 32'h0,  26'h100, 32'h0, 32'h504, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h400, 1,0,0));
    vecs.push_back(mkv(0,0,0,1,1, 32'h400, 32'h0,  26'h200, 32'h0, 32'h404, 0,0,0));
    vecs.push_back(mkv(0,1,1,0,0, 32'h404, 32'h40, 26'h0, 32'h0, 32'h800, 1,0,1));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h804, 0,0,0));
    vecs.push_back(mkv(0,1,0,0,0, 32'h800, 32'h100,26'h0, 32'h0, 32'h808, 0,0,0));
    vecs.push_back(mkv(0,1,1,0,0, 32'h804, 32'h6,  26'h0, 32'h0, 32'h80C, 1,1,0));
    vecs.push_back(mkv(0,1,1,1,0, 32'h808, 32'h10, 26'h0, 32'h2000, 32'h2000, 1,0,0));
    vecs.push_back(mkv(0,1,1,0,0, 32'h100, 32'h10, 26'h0, 32'h0, 32'h114, 1,0,0));
    vecs.push_back(mkv(0,0,0,1,0, 32'h110, 32'h0,  26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h0, 0,0,0));
    vecs.push_back(mkv(1,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h0, 0,0,0));
    vecs.push_back(mkv(0,0,0,1,1, 32'h0,   32'h0,  26'h3FF_FFFF, 32'h0, 32'h4, 0,0,0));
    vecs.push_back(mkv(1,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h4, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h0FFF_FFFC, 1,0,0));
    vecs.push_back(mkv(1,0,0,1,0, 32'h0FFF_FFF8, 32'h0, 26'h0, 32'h1002, 32'h0FFF_FFFC, 0,1,0));
    vecs.push_back(mkv(1,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h0FFF_FFFC, 0,0,0));
    vecs.push_back(mkv(1,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h0FFF_FFFC, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h1000, 1,0,0));
    vecs.push_back(mkv(1,1,1,0,0, 32'h2000, 32'h0, 26'h0, 32'h0, 32'h1000, 0,0,0));
    vecs.push_back(mkv(1,0,0,1,0, 32'h5000, 32'h0, 26'h0, 32'h3000, 32'h1000, 0,0,1));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h2004, 1,0,0));
    vecs.push_back(mkv(1,0,0,1,1, 32'h2004, 32'h0, 26'h10, 32'h0, 32'h2004, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h2008, 0,0,0));
    vecs.push_back(mkv(0,0,0,0,0, 32'h0,   32'h0,  26'h0, 32'h0, 32'h40, 1,0,0));

    s = idle();
    w_stall = 0; w_branch_op = 0; w_success = 0; w_jump_op = 0; w_imm_op = 0;
    w_link = 0; w_ret = 0; w_br_pc_in = '0; w_alu_imm = '0; w_br_imm_26 = '0; w_reg_pc = '0;
    w_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge w_clk);
    check("reset_pc", w_pc, 32'h400);
    check("reset_redirect", 32'(w_redirect), 32'd0);
    check("reset_pulses", 32'({w_misalign, w_redir_drop, w_ras_hit, w_ras_miss}), 32'd0);
    w_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].s);
      check($sformatf("vec%0d_pc", i), w_pc, vecs[i].pc);
      check($sformatf("vec%0d_redirect", i), 32'(w_redirect), 32'(vecs[i].red));
      check($sformatf("vec%0d_misalign", i), 32'(w_misalign), 32'(vecs[i].mis));
      check($sformatf("vec%0d_drop", i), 32'(w_redir_drop), 32'(vecs[i].drop));
    end

    // Reset while a delay-slot redirect is outstanding discards it.
    s = idle(); s.jmp = 1; s.immop = 1; s.br_pc = 32'h40; s.imm26 = 26'h80;
    apply(s);
    check("slot_pc", w_pc, 32'h44);
    w_rst_n = 1'b0;
    #1;
    check("async_reset_pc", w_pc, 32'h400);
    model_reset();
    @(negedge w_clk);
    w_rst_n = 1'b1;
    apply(idle());
    check("after_reset_pc", w_pc, 32'h404);
    check("after_reset_redirect", 32'(w_redirect), 32'd0);

    // Return stack: three links into a two-entry stack, then three returns.
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.jmp = 1; s.immop = 1; s.link = 1;
      s.br_pc = 32'(i) << 8; s.imm26 = 26'h1000;
      apply(s);
    end
    for (int i = 3; i >= 1; i--) begin
      s = idle(); s.jmp = 1; s.ret = 1; s.br_pc = 32'h300;
      s.reg_pc = (32'(i) << 8) + 32'h8;
      apply(s);
`ifdef NPC_RAS_EN
      exp_hit = (i != 1); exp_miss = (i == 1);
`else
      exp_hit = 0; exp_miss = 0;
`endif
      check($sformatf("ras_ret%0d_hit", i), 32'(w_ras_hit), 32'(exp_hit));
      check($sformatf("ras_ret%0d_miss", i), 32'(w_ras_miss), 32'(exp_miss));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 3) begin
        s.jmp = $urandom_range(0, 1) == 1;
        s.br = $urandom_range(0, 1) == 1;
        s.succ = $urandom_range(0, 3) != 0;
        s.immop = $urandom_range(0, 1) == 1;
        s.link = $urandom_range(0, 2) == 0;
        s.ret = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 2))
          0: s.br_pc = m_pc;
          1: s.br_pc = m_pc - 32'd4;
          default: s.br_pc = $urandom & 32'hFFFF_FFFC;
        endcase
        v = int'($urandom_range(0, 511)) - 256;
        s.alu = 32'(v * 4) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
        s.imm26 = 26'($urandom);
        if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) s.reg_pc = m_ras[m_ras.size()-1];
        else s.reg_pc = $urandom;
      end
      apply(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
